// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter_if
// Fetch/data requester signals and shared memory port signals for the arbiter.
// Revision: 1.0
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [31:0]       i_rdata;

  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_we;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;

  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic [3:0]        m_we;
  logic [31:0]       m_rdata;

  // Arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_wdata, d_we, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output m_addr, m_wdata, m_we
  );

  // Requester and memory side
  modport master (
    output i_req, i_addr, d_req, d_addr, d_wdata, d_we, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  m_addr, m_wdata, m_we
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter
// Round-robin arbiter sharing one single-cycle memory port between fetch and data.
// Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W = 32
) (
  input  wire logic         clk,
  input  wire logic         reset,
  mem_port_arbiter_if.slave bus
);

  logic              r_last_d;   // 1: D was granted most recently
  logic              r_pending;
  logic              r_owner_d;
  logic              r_wr;

  logic              w_i_gnt;
  logic              w_d_gnt;
  logic              w_i_rvalid;
  logic              w_d_rvalid;
  logic [ADDR_W-1:0] w_m_addr;
  logic [31:0]       w_m_wdata;
  logic [3:0]        w_m_we;

  always_comb begin
    w_i_gnt = 1'b0;
    w_d_gnt = 1'b0;
    if (!reset) begin
      if (bus.i_req && bus.d_req) begin
        w_i_gnt = r_last_d;
        w_d_gnt = !r_last_d;
      end else begin
        w_i_gnt = bus.i_req;
        w_d_gnt = bus.d_req;
      end
    end
  end

  always_comb begin
    w_m_addr  = bus.i_addr;
    w_m_wdata = 32'd0;
    w_m_we    = 4'd0;
    if (w_d_gnt) begin
      w_m_addr  = bus.d_addr;
      w_m_wdata = bus.d_wdata;
      w_m_we    = bus.d_we;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_d  <= 1'b0;
      r_pending <= 1'b0;
      r_owner_d <= 1'b0;
      r_wr      <= 1'b0;
    end else begin
      r_pending <= w_i_gnt | w_d_gnt;
      r_owner_d <= w_d_gnt;
      r_wr      <= w_d_gnt && (bus.d_we != 4'd0);
      if (w_i_gnt || w_d_gnt) begin
        r_last_d <= w_d_gnt;
      end
    end
  end

  // Reset in the response cycle drops the outstanding response.
  assign w_i_rvalid = r_pending && !r_owner_d && !reset;
  assign w_d_rvalid = r_pending &&  r_owner_d && !reset;

  assign bus.i_gnt    = w_i_gnt;
  assign bus.d_gnt    = w_d_gnt;
  assign bus.i_rvalid = w_i_rvalid;
  assign bus.d_rvalid = w_d_rvalid;
  assign bus.i_rdata  = w_i_rvalid ? bus.m_rdata : 32'd0;
  assign bus.d_rdata  = (w_d_rvalid && !r_wr) ? bus.m_rdata : 32'd0;
  assign bus.m_addr   = w_m_addr;
  assign bus.m_wdata  = w_m_wdata;
  assign bus.m_we     = w_m_we;

endmodule
`default_nettype wire
